// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared constants and FSM state type for the BK-0010 keyboard controller
package kbd_pkg;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_RSHIFT   = 8'h59;

    localparam logic [7:0] VEC_KBD     = 8'o060;
    localparam logic [7:0] VEC_KBD_AR2 = 8'o274;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        LOOKUP  = 3'd3,
        DELIVER = 3'd4
    } kbd_state_e;

endpackage

// File: rtl/kbd_ctrl.sv
// rtl/kbd_ctrl.sv - PS/2 prefix decoder and BK keyboard register/interrupt logic
module kbd_ctrl
    import kbd_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 1 << 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic [7:0] tr_code,
    output logic       tr_shift,
    input  logic [6:0] tr_ascii,
    input  logic       tr_ar2,
    output logic [6:0] key_data,
    output logic       key_ready,
    output logic       key_down,
    input  logic       irq_mask,
    input  logic       rd_data,
    output logic       irq_req,
    output logic [7:0] irq_vector,
    input  logic       irq_ack
);

    localparam int CW = $clog2(PREFIX_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(PREFIX_TIMEOUT - 1);

    kbd_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0] tr_code_q, tr_code_d;
    logic [7:0] last_key_q, last_key_d;
    logic [7:0] irq_vector_q, irq_vector_d;
    logic [6:0] key_data_q, key_data_d;
    logic tr_shift_q, tr_shift_d;
    logic shift_q, shift_d;
    logic ext_q, ext_d;
    logic key_ready_q, key_ready_d;
    logic key_down_q, key_down_d;
    logic irq_req_q, irq_req_d;
    logic mask_q;

    logic timeout;
    logic in_prefix;
    logic deliver;
    logic latch;
    logic mask_rise;

    assign in_prefix = (state_q == EXT) || (state_q == BRK);
    assign timeout   = in_prefix && !scan_valid && (cnt_q == CNT_LIMIT);
    assign deliver   = (state_q == DELIVER) && (tr_ascii != 7'd0);
    assign latch     = scan_valid && (state_d == LOOKUP) && (state_q != LOOKUP);
    assign mask_rise = irq_mask && !mask_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode of prefix bytes, timeout and the two busy states
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (scan_valid) begin
                if (scan_code == SC_BREAK)       state_d = BRK;
                else if (scan_code == SC_EXT)    state_d = EXT;
                else if (scan_code == SC_LSHIFT) state_d = IDLE;
                else                             state_d = LOOKUP;
            end
            EXT: if (scan_valid) begin
                if (scan_code == SC_BREAK)       state_d = BRK;
                else if (scan_code == SC_EXT)    state_d = EXT;
                else if (scan_code == SC_LSHIFT || scan_code == SC_RSHIFT) state_d = IDLE;
                else                             state_d = LOOKUP;
            end else if (timeout) begin
                state_d = IDLE;
            end
            BRK: if (scan_valid || timeout) state_d = IDLE;
            LOOKUP:  state_d = DELIVER;
            DELIVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the datapath and register-visible outputs
    always_comb begin
        cnt_d        = '0;
        tr_code_d    = tr_code_q;
        tr_shift_d   = tr_shift_q;
        shift_d      = shift_q;
        ext_d        = ext_q;
        last_key_d   = last_key_q;
        key_data_d   = key_data_q;
        key_ready_d  = key_ready_q;
        key_down_d   = key_down_q;
        irq_req_d    = irq_req_q;
        irq_vector_d = irq_vector_q;

        // Counter restarts on every state entry and on any byte
        if (in_prefix && !scan_valid && state_d == state_q) cnt_d = cnt_q + 1'b1;

        if (latch) begin
            tr_code_d  = scan_code;
            tr_shift_d = shift_q;
        end

        if (state_q == IDLE && scan_valid && scan_code == SC_LSHIFT) shift_d = 1'b1;
        if (state_q == BRK && scan_valid) begin
            if (scan_code == SC_LSHIFT)  shift_d    = 1'b0;
            if (scan_code == last_key_q) key_down_d = 1'b0;
        end

        if (state_d == EXT) ext_d = 1'b1;
        if (state_q == DELIVER || (in_prefix && state_d == IDLE)) ext_d = 1'b0;

        if (rd_data) key_ready_d = 1'b0;
        if (irq_ack || rd_data || mask_rise) irq_req_d = 1'b0;

        // A delivery overrides any same-cycle read or acknowledge
        if (deliver) begin
            key_data_d   = tr_ascii;
            key_ready_d  = 1'b1;
            key_down_d   = 1'b1;
            last_key_d   = tr_code_q;
            irq_vector_d = tr_ar2 ? VEC_KBD_AR2 : VEC_KBD;
            if (!irq_mask) irq_req_d = 1'b1;
        end
    end

    // Datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            tr_code_q    <= 8'd0;
            tr_shift_q   <= 1'b0;
            shift_q      <= 1'b0;
            ext_q        <= 1'b0;
            last_key_q   <= 8'd0;
            key_data_q   <= 7'd0;
            key_ready_q  <= 1'b0;
            key_down_q   <= 1'b0;
            irq_req_q    <= 1'b0;
            irq_vector_q <= VEC_KBD;
            mask_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            tr_code_q    <= tr_code_d;
            tr_shift_q   <= tr_shift_d;
            shift_q      <= shift_d;
            ext_q        <= ext_d;
            last_key_q   <= last_key_d;
            key_data_q   <= key_data_d;
            key_ready_q  <= key_ready_d;
            key_down_q   <= key_down_d;
            irq_req_q    <= irq_req_d;
            irq_vector_q <= irq_vector_d;
            mask_q       <= irq_mask;
        end
    end

    assign tr_code    = tr_code_q;
    assign tr_shift   = tr_shift_q;
    assign key_data   = key_data_q;
    assign key_ready  = key_ready_q;
    assign key_down   = key_down_q;
    assign irq_req    = irq_req_q;
    assign irq_vector = irq_vector_q;

endmodule

// File: tb/tb_kbd_ctrl.sv
// tb/tb_kbd_ctrl.sv - directed self-checking bench for kbd_ctrl
module tb_kbd_ctrl;

    localparam int PT = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scan_valid = 1'b0;
    logic [7:0] scan_code = 8'd0;
    logic [7:0] tr_code;
    logic       tr_shift;
    logic [6:0] tr_ascii;
    logic       tr_ar2;
    logic [6:0] key_data;
    logic       key_ready;
    logic       key_down;
    logic       irq_mask = 1'b0;
    logic       rd_data = 1'b0;
    logic       irq_req;
    logic [7:0] irq_vector;
    logic       irq_ack = 1'b0;

    int tests = 0;
    int fails = 0;

    kbd_ctrl #(.PREFIX_TIMEOUT(PT)) dut (
        .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code),
        .tr_code(tr_code), .tr_shift(tr_shift), .tr_ascii(tr_ascii), .tr_ar2(tr_ar2),
        .key_data(key_data), .key_ready(key_ready), .key_down(key_down),
        .irq_mask(irq_mask), .rd_data(rd_data), .irq_req(irq_req),
        .irq_vector(irq_vector), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    // Small translator model: A key, 1 key, F1 (AR2), keypad 8 / up arrow
    always_comb begin
        tr_ascii = 7'd0;
        tr_ar2   = 1'b0;
        case (tr_code)
            8'h1C: tr_ascii = tr_shift ? 7'h41 : 7'h61;
            8'h16: tr_ascii = tr_shift ? 7'h21 : 7'h31;
            8'h05: begin tr_ascii = 7'o001; tr_ar2 = 1'b1; end
            8'h75: tr_ascii = 7'o032;
            default: tr_ascii = 7'd0;
        endcase
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); scan_valid = 1'b1; scan_code = b;
        @(negedge clk); scan_valid = 1'b0;
    endtask

    task automatic press(input logic [7:0] b);
        send_byte(b);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_rd();
        @(negedge clk); rd_data = 1'b1;
        @(negedge clk); rd_data = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tests++; if (key_data !== 7'd0) begin fails++; $display("FAIL reset_key_data: got %h want 0", key_data); end
        tests++; if (key_ready !== 1'b0) begin fails++; $display("FAIL reset_key_ready: got %b want 0", key_ready); end
        tests++; if (key_down !== 1'b0) begin fails++; $display("FAIL reset_key_down: got %b want 0", key_down); end
        tests++; if (irq_req !== 1'b0) begin fails++; $display("FAIL reset_irq_req: got %b want 0", irq_req); end
        tests++; if (irq_vector !== 8'o060) begin fails++; $display("FAIL reset_irq_vector: got %o want 060", irq_vector); end
        tests++; if (tr_code !== 8'd0) begin fails++; $display("FAIL reset_tr_code: got %h want 0", tr_code); end
    endtask

    task automatic test_press_timing();
        send_byte(8'h1C);
        tests++; if (tr_code !== 8'h1C) begin fails++; $display("FAIL t1_tr_code: got %h want 1c", tr_code); end
        tests++; if (tr_shift !== 1'b0) begin fails++; $display("FAIL t1_tr_shift: got %b want 0", tr_shift); end
        tests++; if (key_ready !== 1'b0) begin fails++; $display("FAIL t1_key_ready_early: got %b want 0", key_ready); end
        @(negedge clk);
        tests++; if (key_ready !== 1'b0) begin fails++; $display("FAIL t2_key_ready_early: got %b want 0", key_ready); end
        @(negedge clk);
        tests++; if (key_data !== 7'h61) begin fails++; $display("FAIL t3_key_data: got %h want 61", key_data); end
        tests++; if (key_ready !== 1'b1) begin fails++; $display("FAIL t3_key_ready: got %b want 1", key_ready); end
        tests++; if (irq_req !== 1'b1) begin fails++; $display("FAIL t3_irq_req: got %b want 1", irq_req); end
        tests++; if (irq_vector !== 8'o060) begin fails++; $display("FAIL t3_irq_vector: got %o want 060", irq_vector); end
        tests++; if (key_down !== 1'b1) begin fails++; $display("FAIL t3_key_down: got %b want 1", key_down); end
        rd_data = 1'b1;
        @(negedge clk); rd_data = 1'b0;
        tests++; if (key_ready !== 1'b0) begin fails++; $display("FAIL rd_key_ready: got %b want 0", key_ready); end
        tests++; if (irq_req !== 1'b0) begin fails++; $display("FAIL rd_irq_req: got %b want 0", irq_req); end
    endtask

    task automatic test_shift_release();
        send_byte(8'h12);
        press(8'h1C);
        tests++; if (key_data !== 7'h41) begin fails++; $display("FAIL shift_key_data: got %h want 41", key_data); end
        pulse_rd();
        send_byte(8'hF0);
        press(8'h1C);
        tests++; if (key_down !== 1'b0) begin fails++; $display("FAIL release_key_down: got %b want 0", key_down); end
        tests++; if (key_ready !== 1'b0) begin fails++; $display("FAIL release_no_delivery: got %b want 0", key_ready); end
        tests++; if (key_data !== 7'h41) begin fails++; $display("FAIL release_key_data: got %h want 41", key_data); end
        send_byte(8'hF0);
        send_byte(8'h12);
        press(8'h1C);
        tests++; if (key_data !== 7'h61) begin fails++; $display("FAIL unshift_key_data: got %h want 61", key_data); end
        tests++; if (tr_shift !== 1'b0) begin fails++; $display("FAIL unshift_tr_shift: got %b want 0", tr_shift); end
    endtask

    task automatic test_ar2_ext();
        press(8'h05);
        tests++; if (key_data !== 7'o001) begin fails++; $display("FAIL f1_key_data: got %o want 001", key_data); end
        tests++; if (irq_vector !== 8'o274) begin fails++; $display("FAIL f1_irq_vector: got %o want 274", irq_vector); end
        send_byte(8'hE0);
        press(8'h75);
        tests++; if (key_data !== 7'o032) begin fails++; $display("FAIL ext_key_data: got %o want 032", key_data); end
        tests++; if (irq_vector !== 8'o060) begin fails++; $display("FAIL ext_irq_vector: got %o want 060", irq_vector); end
        send_byte(8'hE0);
        send_byte(8'h12);
        press(8'h1C);
        tests++; if (key_data !== 7'h61) begin fails++; $display("FAIL fake_shift_key_data: got %h want 61", key_data); end
    endtask

    task automatic test_mask_collisions();
        pulse_rd();
        irq_mask = 1'b1;
        press(8'h16);
        tests++; if (key_ready !== 1'b1) begin fails++; $display("FAIL masked_key_ready: got %b want 1", key_ready); end
        tests++; if (irq_req !== 1'b0) begin fails++; $display("FAIL masked_irq_req: got %b want 0", irq_req); end
        tests++; if (key_data !== 7'h31) begin fails++; $display("FAIL masked_key_data: got %h want 31", key_data); end
        irq_mask = 1'b0;
        pulse_rd();
        send_byte(8'h1C);
        @(negedge clk); rd_data = 1'b1;
        @(negedge clk); rd_data = 1'b0;
        tests++; if (key_ready !== 1'b1) begin fails++; $display("FAIL rd_collision_key_ready: got %b want 1", key_ready); end
        send_byte(8'h16);
        @(negedge clk); irq_ack = 1'b1;
        @(negedge clk); irq_ack = 1'b0;
        tests++; if (irq_req !== 1'b1) begin fails++; $display("FAIL ack_collision_irq_req: got %b want 1", irq_req); end
        irq_mask = 1'b1;
        @(negedge clk);
        tests++; if (irq_req !== 1'b0) begin fails++; $display("FAIL mask_rise_irq_req: got %b want 0", irq_req); end
        irq_mask = 1'b0;
        press(8'h1C);
        irq_ack = 1'b1;
        @(negedge clk); irq_ack = 1'b0;
        tests++; if (irq_req !== 1'b0) begin fails++; $display("FAIL ack_irq_req: got %b want 0", irq_req); end
        tests++; if (key_ready !== 1'b1) begin fails++; $display("FAIL ack_keeps_ready: got %b want 1", key_ready); end
    endtask

    task automatic test_unmapped_timeout();
        press(8'h01);
        tests++; if (key_data !== 7'h61) begin fails++; $display("FAIL unmapped_key_data: got %h want 61", key_data); end
        tests++; if (key_ready !== 1'b1) begin fails++; $display("FAIL unmapped_key_ready: got %b want 1", key_ready); end
        tests++; if (irq_req !== 1'b0) begin fails++; $display("FAIL unmapped_irq_req: got %b want 0", irq_req); end
        pulse_rd();
        send_byte(8'hF0);
        repeat (PT + 2) @(negedge clk);
        press(8'h1C);
        tests++; if (key_data !== 7'h61) begin fails++; $display("FAIL timeout_key_data: got %h want 61", key_data); end
        tests++; if (key_ready !== 1'b1) begin fails++; $display("FAIL timeout_key_ready: got %b want 1", key_ready); end
        tests++; if (key_down !== 1'b1) begin fails++; $display("FAIL timeout_key_down: got %b want 1", key_down); end
    endtask

    task automatic test_reset_in_brk();
        send_byte(8'h12);
        send_byte(8'hF0);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        tests++; if (key_ready !== 1'b0) begin fails++; $display("FAIL rst_brk_key_ready: got %b want 0", key_ready); end
        tests++; if (key_data !== 7'd0) begin fails++; $display("FAIL rst_brk_key_data: got %h want 0", key_data); end
        tests++; if (key_down !== 1'b0) begin fails++; $display("FAIL rst_brk_key_down: got %b want 0", key_down); end
        tests++; if (irq_vector !== 8'o060) begin fails++; $display("FAIL rst_brk_irq_vector: got %o want 060", irq_vector); end
        press(8'h1C);
        tests++; if (key_data !== 7'h61) begin fails++; $display("FAIL rst_brk_make_data: got %h want 61", key_data); end
        tests++; if (key_ready !== 1'b1) begin fails++; $display("FAIL rst_brk_make_ready: got %b want 1", key_ready); end
    endtask

    initial begin
        test_reset();
        test_press_timing();
        test_shift_release();
        test_ar2_ext();
        test_mask_collisions();
        test_unmapped_timeout();
        test_reset_in_brk();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
